exec_result_unit: RTL and testbench
===================================

# exec_result_unit

Execute stage directly downstream of the reservation station. Each cycle it accepts at most one ready instruction's operands and ROB tag. It computes the result in a single-cycle ALU or a pipelined multiplier, then queues results in an in-order output buffer that is broadcast one per cycle on the CDB under a grant handshake. It drives `exec_stall` back to the reservation station so that no issued instruction is ever dropped.

## Interface
Parameters:
- `MUL_LAT`, 3: multiplier pipeline depth in cycles; must be ≥1.
- `OUT_DEPTH`, 4: output buffer entries; must be a power of two and ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; state is cleared on a posedge where `reset`==0.
- `issue_valid`  in  1  a ready instruction is presented (RS found-ready).
- `issue_tag`  in  `ROB_TAG_LEN`  destination ROB tag (rd_tag).
- `issue_op`  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- `issue_a`  in  32  rs1 value.
- `issue_b`  in  32  rs2 value.
- `flush`  in  1  squash all in-flight and buffered results.
- `cdb_grant`  in  1  CDB arbiter accepts the current head this cycle.
- `exec_stall`  out  1  issue is not accepted this cycle.
- `cdb_valid`  out  1  buffer head is valid.
- `cdb_tag`  out  `ROB_TAG_LEN`  head ROB tag.
- `cdb_value`  out  32  head result.

## Operation
- **Accept:** `accept` = `issue_valid` & !`exec_stall` & !`flush`. The RS retires its entry under the same condition.
- **`exec_stall` source:** driven purely from registered state. `occ` = `fifo_count` + `mul_inflight`, and `exec_stall` = (`occ` ≥ `OUT_DEPTH`). Pops in the current cycle do not release credit until the next cycle, so the rule is conservative.
- **ALU ops (0–6):** computed combinationally from the issue inputs. On an accepting edge the result is written directly into the output buffer.
- **ALU arithmetic:** all results are modulo 2^32. SLL and SRL shift by `issue_b[4:0]`; SRL is logical.
- **MUL (op 7):** enters a `MUL_LAT`-stage valid/tag/product pipeline. The result is the low 32 bits of the unsigned product, written into the buffer when it leaves the last stage.
- **Dual write:** if a MUL completion and an ALU accept occur on the same edge, both are written. The MUL result goes to the lower slot (older) and the ALU result to the next slot.
- **Credit guarantee:** `occ` never exceeds `OUT_DEPTH`, so a buffer write never finds the buffer full.
- **Output buffer:** circular, with head/tail pointers of `log2(OUT_DEPTH)` bits that wrap naturally. A count register is `log2(OUT_DEPTH)+1` bits.
- **CDB outputs:** `cdb_valid` = (count≠0). `cdb_tag`/`cdb_value` show the head entry, and are forced to 0 when empty.
- **Pop:** when `cdb_valid` & `cdb_grant`. If `cdb_grant` arrives while empty, it is ignored.
- **Simultaneous push and pop:** allowed in the same cycle, with count = count + pushes − pop.
- **`flush`:** on that edge, clears the buffer, the mul pipeline valids and the counters. The issue and the pop in that cycle are discarded.
- **`reset`:** has priority over `flush`. It clears pointers, count, mul valids, tags and data to 0.

## Timing
- **Reset values:** `exec_stall`=0, `cdb_valid`=0, `cdb_tag`=0, `cdb_value`=0.
- **ALU latency:** issue accepted in cycle N, result visible on the CDB in cycle N+1 if the buffer was empty.
- **MUL latency:** issue accepted in cycle N, result visible in cycle N+`MUL_LAT`+1 if the buffer was empty.
- **Result order:** CDB order is completion order, not issue order. A MUL issued before an ALU op may broadcast after it.
- **Stall rise:** `exec_stall` rises the cycle after `occ` reaches `OUT_DEPTH`.
- **Stall fall:** `exec_stall` falls the cycle after a pop or flush reduces `occ`.
- **Throughput:** one result per cycle sustained with `cdb_grant` held high.
- **Mid-operation reset:** `reset` low mid-operation loses all in-flight results, with no partial broadcast afterwards.

## Test plan
- **ALU single issue:** reset, then issue ADD tag 5, a=7, b=0xFFFFFFFF, with `cdb_grant`=1 → next cycle `cdb_valid`=1, tag 5, value 6; the cycle after, `cdb_valid`=0.
- **MUL latency:** `MUL_LAT`=3, issue MUL tag 2, a=0x10000, b=0x10000 → `cdb_valid` exactly 4 cycles later with value 0 (low 32 bits).
- **Collision:** issue MUL tag 1 at N, ALU SUB tag 3 (a=1, b=2) at N+3, grant held high → N+4: tag 1; N+5: tag 3, value 0xFFFFFFFF.
- **Backpressure:** `cdb_grant`=0, issue 4 ADDs back to back → `exec_stall`=1 from the 5th cycle. Further `issue_valid` is not accepted. Releasing the grant drains tags in order and `exec_stall` drops the cycle after the first pop.
- **Flush:** 2 MULs in flight and 1 buffered result, assert `flush` one cycle → the next cycle `cdb_valid`=0 and `exec_stall`=0, and no stale MUL ever appears.
- **Mid-op reset and shifts:** `reset`=0 mid-operation → all outputs 0 the next cycle. SLL a=1, b=0x23 → value 8; SRL a=0x80000000, b=31 → value 1.

Source files
------------

// File: rtl/exec_result_unit.sv
// Execute stage behind the reservation station: single-cycle ALU plus a pipelined
// multiplier feeding an in-order result buffer that is broadcast on the CDB.
module exec_result_unit #(
  parameter int MUL_LAT     = 3,
  parameter int OUT_DEPTH   = 4,
  parameter int ROB_TAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ROB_TAG_LEN-1:0] issue_tag,
  input  logic [2:0]             issue_op,
  input  logic [31:0]            issue_a,
  input  logic [31:0]            issue_b,
  input  logic                   flush,
  input  logic                   cdb_grant,
  output logic                   exec_stall,
  output logic                   cdb_valid,
  output logic [ROB_TAG_LEN-1:0] cdb_tag,
  output logic [31:0]            cdb_value
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MUL_LAT + 1);

  // Handshakes: an issue transfers on a posedge where issue_valid & !exec_stall & !flush;
  // a CDB result transfers on a posedge where cdb_valid & cdb_grant (grant while empty is ignored).

  logic [MUL_LAT-1:0]     mul_v;
  logic [ROB_TAG_LEN-1:0] mul_tag [MUL_LAT];
  logic [31:0]            mul_p   [MUL_LAT];

  logic [ROB_TAG_LEN-1:0] buf_tag [OUT_DEPTH];
  logic [31:0]            buf_val [OUT_DEPTH];
  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [AW-1:0]          tail_p1;
  logic [CW-1:0]          fifo_count;

  logic [IW-1:0] mul_inflight;
  logic [31:0]   occ;
  logic [31:0]   alu_res;
  logic [31:0]   mul_prod;
  logic          accept;
  logic          alu_push;
  logic          mul_push;
  logic          mul_done;
  logic          pop;
  logic [1:0]    n_push;

  always_comb begin
    mul_inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      mul_inflight = mul_inflight + IW'(mul_v[i]);
    end
  end

  // Credit counts results already reserved in the pipe, so a write never finds the buffer full.
  assign occ        = 32'(fifo_count) + 32'(mul_inflight);
  assign exec_stall = (occ >= OUT_DEPTH);

  assign accept   = issue_valid & ~exec_stall & ~flush;
  assign alu_push = accept & (issue_op != 3'd7);
  assign mul_push = accept & (issue_op == 3'd7);
  assign mul_done = mul_v[MUL_LAT-1];
  assign mul_prod = issue_a * issue_b;

  always_comb begin
    alu_res = '0;
    case (issue_op)
      3'd0:    alu_res = issue_a + issue_b;
      3'd1:    alu_res = issue_a - issue_b;
      3'd2:    alu_res = issue_a & issue_b;
      3'd3:    alu_res = issue_a | issue_b;
      3'd4:    alu_res = issue_a ^ issue_b;
      3'd5:    alu_res = issue_a << issue_b[4:0];
      3'd6:    alu_res = issue_a >> issue_b[4:0];
      default: alu_res = '0;
    endcase
  end

  assign cdb_valid = (fifo_count != '0);
  assign cdb_tag   = cdb_valid ? buf_tag[head] : '0;
  assign cdb_value = cdb_valid ? buf_val[head] : '0;
  assign pop       = cdb_valid & cdb_grant;
  assign n_push    = {1'b0, mul_done} + {1'b0, alu_push};
  assign tail_p1   = tail + AW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      mul_v      <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        mul_tag[i] <= '0;
        mul_p[i]   <= '0;
      end
      for (int i = 0; i < OUT_DEPTH; i++) begin
        buf_tag[i] <= '0;
        buf_val[i] <= '0;
      end
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      mul_v      <= '0;
    end else begin
      mul_v[0]   <= mul_push;
      mul_tag[0] <= issue_tag;
      mul_p[0]   <= mul_prod;
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_v[i]   <= mul_v[i-1];
        mul_tag[i] <= mul_tag[i-1];
        mul_p[i]   <= mul_p[i-1];
      end
      // A completing multiply is older than the ALU op issued this cycle, so it takes the lower slot.
      if (mul_done) begin
        buf_tag[tail] <= mul_tag[MUL_LAT-1];
        buf_val[tail] <= mul_p[MUL_LAT-1];
      end
      if (alu_push) begin
        buf_tag[mul_done ? tail_p1 : tail] <= issue_tag;
        buf_val[mul_done ? tail_p1 : tail] <= alu_res;
      end
      tail       <= tail + AW'(n_push);
      if (pop) head <= head + AW'(1);
      fifo_count <= fifo_count + CW'(n_push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_exec_result_unit.sv
// Bench for exec_result_unit: directed scenario tasks plus a CDB scoreboard fed at issue time.
module tb_exec_result_unit;

  localparam int MUL_LAT   = 3;
  localparam int OUT_DEPTH = 4;
  localparam int TW        = 5;

  logic          clk;
  logic          reset;
  logic          issue_valid;
  logic [TW-1:0] issue_tag;
  logic [2:0]    issue_op;
  logic [31:0]   issue_a;
  logic [31:0]   issue_b;
  logic          flush;
  logic          cdb_grant;
  logic          exec_stall;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_value;

  logic [TW+31:0] exp_q[$];
  logic [TW+31:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;

  exec_result_unit #(.MUL_LAT(MUL_LAT), .OUT_DEPTH(OUT_DEPTH), .ROB_TAG_LEN(TW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b), .flush(flush),
    .cdb_grant(cdb_grant), .exec_stall(exec_stall), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return a * b;
    endcase
  endfunction

  // scoreboard: every granted broadcast must match the oldest expected result
  always @(negedge clk) begin
    if (reset && !flush && cdb_valid && cdb_grant) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cdb_unexpected: got tag %0d value %h, required no broadcast", cdb_tag, cdb_value);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({cdb_tag, cdb_value} !== mon_exp) begin
          n_fail++;
          $display("FAIL cdb_result: got tag %0d value %h, required tag %0d value %h",
                   cdb_tag, cdb_value, mon_exp[TW+31:32], mon_exp[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [TW-1:0] tag, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_push);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag   = tag;
    issue_a     = a;
    issue_b     = b;
    if (expect_push) exp_q.push_back({tag, alu_model(op, a, b)});
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d results still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty_after_drain: cdb_valid=%b, required 0", name, cdb_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({exec_stall, cdb_valid, cdb_tag, cdb_value} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: stall=%b valid=%b tag=%0d value=%h, required all 0",
               exec_stall, cdb_valid, cdb_tag, cdb_value);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_single();
    cdb_grant = 1'b1;
    drive(3'd0, 5'd5, 32'd7, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd5, 32'd6}) begin
      n_fail++;
      $display("FAIL alu_single: valid=%b tag=%0d value=%h, required 1/5/6", cdb_valid, cdb_tag, cdb_value);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_single_after: cdb_valid=%b, required 0", cdb_valid);
    end
    tick();
  endtask

  task automatic test_mul_latency();
    cdb_grant = 1'b1;
    drive(3'd7, 5'd2, 32'h0001_0000, 32'h0001_0000, 1'b1);
    tick();
    idle();
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clk);
      n_checks++;
      if (cdb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_early_cycle%0d: cdb_valid=%b, required 0", k, cdb_valid);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL mul_latency: valid=%b tag=%0d value=%h, required 1/2/0", cdb_valid, cdb_tag, cdb_value);
    end
    tick();
    drain("mul_latency");
  endtask

  task automatic test_collision();
    cdb_grant = 1'b1;
    drive(3'd7, 5'd1, 32'd3, 32'd5, 1'b1);
    tick();
    idle();
    tick();
    tick();
    drive(3'd1, 5'd3, 32'd1, 32'd2, 1'b1);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd1, 32'd15}) begin
      n_fail++;
      $display("FAIL collision_mul_first: valid=%b tag=%0d value=%h, required 1/1/f", cdb_valid, cdb_tag, cdb_value);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd3, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL collision_alu_second: valid=%b tag=%0d value=%h, required 1/3/ffffffff",
               cdb_valid, cdb_tag, cdb_value);
    end
    tick();
    drain("collision");
  endtask

  task automatic test_back_to_back();
    cdb_grant = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(3'($urandom_range(0, 6)), 5'(k + 16), $urandom, $urandom, 1'b1);
      @(negedge clk);
      n_checks++;
      if (exec_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_back_stall%0d: exec_stall=%b, required 0", k, exec_stall);
      end
      tick();
    end
    idle();
    drain("back_to_back");
  endtask

  task automatic test_backpressure();
    cdb_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(3'd0, 5'(10 + k), 32'(k), 32'd100, 1'b1);
      @(negedge clk);
      n_checks++;
      if (exec_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_fill%0d: exec_stall=%b, required 0", k, exec_stall);
      end
      tick();
    end
    drive(3'd0, 5'd14, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    n_checks++;
    if (exec_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall_rise: exec_stall=%b, required 1", exec_stall);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({exec_stall, cdb_valid, cdb_tag} !== {1'b1, 1'b1, 5'd10}) begin
      n_fail++;
      $display("FAIL bp_hold: stall=%b valid=%b tag=%0d, required 1/1/10", exec_stall, cdb_valid, cdb_tag);
    end
    tick();
    idle();
    cdb_grant = 1'b1;
    @(negedge clk);
    n_checks++;
    if (exec_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop_cycle: exec_stall=%b, required 1", exec_stall);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (exec_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall_fall: exec_stall=%b, required 0", exec_stall);
    end
    tick();
    drain("backpressure");
  endtask

  task automatic test_flush();
    cdb_grant = 1'b0;
    drive(3'd0, 5'd20, 32'd1, 32'd1, 1'b0);
    tick();
    drive(3'd7, 5'd21, 32'd2, 32'd3, 1'b0);
    tick();
    drive(3'd7, 5'd22, 32'd4, 32'd5, 1'b0);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, exec_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_clear: valid=%b stall=%b, required 0/0", cdb_valid, exec_stall);
    end
    cdb_grant = 1'b1;
    for (int k = 0; k < MUL_LAT + 3; k++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (cdb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale%0d: cdb_valid=%b tag=%0d, required 0", k, cdb_valid, cdb_tag);
      end
    end
    tick();
    drive(3'd4, 5'd23, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    tick();
    idle();
    drain("flush");
  endtask

  task automatic test_reset_shifts();
    cdb_grant = 1'b0;
    drive(3'd0, 5'd7, 32'd1, 32'd2, 1'b0);
    tick();
    drive(3'd7, 5'd8, 32'd3, 32'd3, 1'b0);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({exec_stall, cdb_valid, cdb_tag, cdb_value} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: stall=%b valid=%b tag=%0d value=%h, required all 0",
               exec_stall, cdb_valid, cdb_tag, cdb_value);
    end
    for (int k = 0; k < MUL_LAT + 2; k++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (cdb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_reset_stale%0d: cdb_valid=%b tag=%0d, required 0", k, cdb_valid, cdb_tag);
      end
    end
    tick();
    cdb_grant = 1'b1;
    drive(3'd5, 5'd4, 32'd1, 32'h23, 1'b1);
    tick();
    drive(3'd6, 5'd6, 32'h8000_0000, 32'd31, 1'b1);
    tick();
    idle();
    drain("shifts");
  endtask

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    cdb_grant   = 1'b0;
    issue_valid = 1'b0;
    issue_tag   = '0;
    issue_op    = '0;
    issue_a     = '0;
    issue_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_alu_single();
    test_mul_latency();
    test_collision();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_shifts();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d results never broadcast, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
